// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage: registered writeback port, status flags, iterative multiply when ALU_MUL_EN is defined
module alu_exec_stage #(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [RADDR_W-1:0] dest,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_dr,
    output logic [WIDTH-1:0]   wb_data,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v,
    output logic               busy
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam int         MSB    = WIDTH - 1;

    logic               wb_en_q, wb_en_d;
    logic [RADDR_W-1:0] wb_dr_q, wb_dr_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic [3:0]         flags_q, flags_d;   // {z, n, c, v}

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_wr, alu_upd;
    logic [WIDTH:0]     wide;
    logic [3:0]         shamt;
    logic               accept;

    assign shamt = op_b[3:0];

    // Shifts run through a WIDTH+1 vector so the spare bit catches the last bit shifted out.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
        wide    = '0;
        case (opcode)
            OP_ADD: begin
                wide    = {1'b0, op_a} + {1'b0, op_b};
                alu_res = wide[MSB:0];
                alu_c   = wide[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
                alu_wr  = (opcode == OP_SUB);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin
                wide    = {1'b0, op_a} << shamt;
                alu_res = wide[MSB:0];
                alu_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {op_a, 1'b0} >> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SRA: begin
                wide    = $unsigned($signed({op_a, 1'b0}) >>> shamt);
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_MOV: alu_res = op_b;
            default: begin
                alu_wr  = 1'b0;
                alu_upd = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL_RUN} state_e;
    localparam int CNT_W = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [RADDR_W-1:0]   mdest_q, mdest_d;

    assign acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign issue_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_MUL_RUN);
`else
    assign issue_ready = 1'b1;
    assign busy        = 1'b0;
`endif

    assign accept = issue_valid && issue_ready;

    always_comb begin
        wb_en_d   = 1'b0;
        wb_dr_d   = wb_dr_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
`ifdef ALU_MUL_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mdest_d   = mdest_q;
`endif
        if (accept) begin
            if (alu_wr) begin
                wb_en_d   = 1'b1;
                wb_dr_d   = dest;
                wb_data_d = alu_res;
            end
            if (alu_upd) begin
                flags_d = {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
            end
`ifdef ALU_MUL_EN
            if (opcode == OP_MUL) begin
                state_d  = S_MUL_RUN;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, op_a};
                mplier_d = op_b;
                mdest_d  = dest;
            end
`endif
        end
`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the final step commits straight from acc_step.
        if (state_q == S_MUL_RUN) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d   = S_IDLE;
                wb_en_d   = 1'b1;
                wb_dr_d   = mdest_q;
                wb_data_d = acc_step[MSB:0];
                flags_d   = {(acc_step[MSB:0] == '0), acc_step[MSB],
                             |acc_step[2*WIDTH-1:WIDTH], |acc_step[2*WIDTH-1:WIDTH]};
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_en_q   <= 1'b0;
            wb_dr_q   <= '0;
            wb_data_q <= '0;
            flags_q   <= '0;
`ifdef ALU_MUL_EN
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mdest_q   <= '0;
`endif
        end else begin
            wb_en_q   <= wb_en_d;
            wb_dr_q   <= wb_dr_d;
            wb_data_q <= wb_data_d;
            flags_q   <= flags_d;
`ifdef ALU_MUL_EN
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mdest_q   <= mdest_d;
`endif
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_dr   = wb_dr_q;
    assign wb_data = wb_data_q;
    assign flag_z  = flags_q[3];
    assign flag_n  = flags_q[2];
    assign flag_c  = flags_q[1];
    assign flag_v  = flags_q[0];

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage (directed plan plus randomized ops vs arithmetic model)
module tb_alu_exec_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  opcode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  dest;
    logic        wb_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected state: countdown of multiply cycles left plus the values the stage should show.
    logic        e_wb_en;
    logic [2:0]  e_dr;
    logic [15:0] e_data;
    logic        e_z, e_n, e_c, e_v;
    int          e_left;
    logic [2:0]  p_dr;
    logic [15:0] p_data;
    logic        p_cv;

    logic [15:0] corner_vals [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    alu_exec_stage #(.WIDTH(16), .RADDR_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .op_a        (op_a),
        .op_b        (op_b),
        .dest        (dest),
        .wb_en       (wb_en),
        .wb_dr       (wb_dr),
        .wb_data     (wb_data),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic c, output logic v,
                           output logic wr, output logic upd);
        int     sa, sb, s, t, sh;
        longint u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        r = 16'h0; c = 1'b0; v = 1'b0; wr = 1'b1; upd = 1'b1;
        case (op)
            4'd0: begin
                u = longint'(a) + longint'(b);
                r = u[15:0];
                c = (u > 64'sd65535);
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd11: begin
                r = a - b;
                c = (a < b);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
                wr = (op == 4'd1);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[16 - sh];
            end
            4'd7: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            4'd8: begin
                s = sa >>> sh;
                r = s[15:0];
                t = sa >>> ((sh == 0) ? 0 : sh - 1);
                c = (sh == 0) ? 1'b0 : t[0];
            end
            4'd9: r = b;
`ifdef ALU_MUL_EN
            4'd10: begin
                u = longint'(a) * longint'(b);
                r = u[15:0];
                c = (u > 64'sd65535);
                v = c;
            end
`endif
            default: begin
                wr = 1'b0;
                upd = 1'b0;
            end
        endcase
    endtask

    task automatic model_reset();
        e_wb_en = 1'b0; e_dr = 3'd0; e_data = 16'h0;
        e_z = 1'b0; e_n = 1'b0; e_c = 1'b0; e_v = 1'b0;
        e_left = 0;
    endtask

    task automatic model_edge(input logic vld, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [2:0] d);
        logic [15:0] r;
        logic c, v, wr, upd;
        e_wb_en = 1'b0;
        if (e_left > 0) begin
            e_left--;
            if (e_left == 0) begin
                e_wb_en = 1'b1; e_dr = p_dr; e_data = p_data;
                e_z = (p_data == 16'h0); e_n = p_data[15]; e_c = p_cv; e_v = p_cv;
            end
        end else if (vld) begin
            ref_alu(op, a, b, r, c, v, wr, upd);
`ifdef ALU_MUL_EN
            if (op == 4'd10) begin
                e_left = 16; p_dr = d; p_data = r; p_cv = c;
                wr = 1'b0; upd = 1'b0;
            end
`endif
            if (wr) begin
                e_wb_en = 1'b1; e_dr = d; e_data = r;
            end
            if (upd) begin
                e_z = (r == 16'h0); e_n = r[15]; e_c = c; e_v = v;
            end
        end
    endtask

    task automatic check_all();
        check("wb_en", 32'(wb_en), 32'(e_wb_en));
        check("wb_dr", 32'(wb_dr), 32'(e_dr));
        check("wb_data", 32'(wb_data), 32'(e_data));
        check("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'({e_z, e_n, e_c, e_v}));
        check("issue_ready", 32'(issue_ready), 32'(e_left == 0));
        check("busy", 32'(busy), 32'(e_left != 0));
    endtask

    task automatic cycle(input logic vld, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d);
        issue_valid = vld; opcode = op; op_a = a; op_b = b; dest = d;
        @(posedge clock);
        #1;
        model_edge(vld, op, a, b, d);
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_dr", 32'(wb_dr), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 3) == 0) return corner_vals[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        reset = 1'b0; issue_valid = 1'b0; opcode = 4'd0; op_a = 16'h0; op_b = 16'h0; dest = 3'd0;
        model_reset();
        do_reset();
        cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        check("ready_after_rst", 32'(issue_ready), 32'd1);

        // Reset during a run of single-cycle ops.
        cycle(1'b1, 4'd0, 16'h1234, 16'h0101, 3'd2);
        cycle(1'b1, 4'd4, 16'hFFFF, 16'h00FF, 3'd6);
        do_reset();
        cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        check("ready_after_rst2", 32'(issue_ready), 32'd1);

        cycle(1'b1, 4'd0, 16'h7FFF, 16'h0001, 3'd3);
        check("add_wb_data", 32'(wb_data), 32'h8000);
        check("add_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b0101);

        cycle(1'b1, 4'd1, 16'h0003, 16'h0004, 3'd1);
        check("sub_wb_data", 32'(wb_data), 32'hFFFF);
        check("sub_c_n", 32'({flag_c, flag_n}), 32'b11);
        cycle(1'b1, 4'd11, 16'h0005, 16'h0005, 3'd4);
        check("cmp_no_wb", 32'(wb_en), 32'd0);
        check("cmp_z_c", 32'({flag_z, flag_c}), 32'b10);

        cycle(1'b1, 4'd6, 16'h8001, 16'h0001, 3'd7);
        check("shl_data_c", 32'({wb_data, flag_c}), 32'({16'h0002, 1'b1}));
        cycle(1'b1, 4'd8, 16'h8000, 16'h0004, 3'd7);
        check("sra_data", 32'(wb_data), 32'hF800);
        cycle(1'b1, 4'd7, 16'h1234, 16'h0000, 3'd0);
        check("shr0_data_c", 32'({wb_data, flag_c}), 32'({16'h1234, 1'b0}));
        cycle(1'b1, 4'd12, 16'h0000, 16'h0000, 3'd5);
        check("nop_no_wb", 32'(wb_en), 32'd0);

        // Multiply with issue attempts while it runs.
        cycle(1'b1, 4'd10, 16'h0100, 16'h0101, 3'd5);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 4'd0, pick(), pick(), 3'd1);
`ifdef ALU_MUL_EN
            check("mul_stall_ready", 32'(issue_ready), 32'd0);
`endif
        end
        cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
`ifdef ALU_MUL_EN
        check("mul_wb", 32'({wb_en, wb_dr, wb_data}), 32'({1'b1, 3'd5, 16'h0100}));
        check("mul_c_v", 32'({flag_c, flag_v}), 32'b11);
`endif
        cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        check("mul_single_pulse", 32'(wb_en), 32'd0);

        // Abort a multiply once its counter has reached 7.
        cycle(1'b1, 4'd10, 16'hFFFF, 16'hFFFF, 3'd2);
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        check("abort_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), pick(), pick(),
                  3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
